vga_frame_reader: RTL and testbench
===================================

Name: vga_frame_reader

Overview:
- Display-side reader of the 256x256 3-bit framebuffer that the CPU fills with VGA pixel-write instructions.
- Generates 640x480@60 VGA timing from the 50 MHz system clock and fetches one framebuffer word per pixel through a synchronous RAM read port.
- Places the 256x256 image in a window on screen and outputs RGB plus sync signals.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- X_OFFSET, 192, first screen column of the image window
- Y_OFFSET, 112, first screen line of the image window

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high reset
- oReadAddress  out  16  framebuffer read address {row[7:0], col[7:0]}
- iReadData  in  3  framebuffer data, valid 1 Clock after address; bit2=R, bit1=G, bit0=B
- oVGA_Red  out  1  red
- oVGA_Green  out  1  green
- oVGA_Blue  out  1  blue
- oVGA_HSync  out  1  horizontal sync, active low
- oVGA_VSync  out  1  vertical sync, active low
- oFrameStart  out  1  one-Clock pulse at start of vertical blanking

Behaviour:
- Reset values: all counters 0, pixel toggle 0, oReadAddress 0, RGB 0, HSync and VSync 1, oFrameStart 0. Reset overrides everything in any cycle; reset mid-frame restarts at hcount=0, vcount=0.
- Pixel tick: a toggle register flips every Clock. pix_en = toggle==1, so the first tick is the 2nd Clock after reset deasserts and the pixel rate is 25 MHz. All state below changes only on pix_en, except oFrameStart.
- Counters:
  - hcount runs 0..H_total-1, where H_total = 800. At wrap it returns to 0 and vcount increments.
  - vcount runs 0..V_total-1, where V_total = 525, and wraps to 0.
- Window: in_win = (hcount - X_OFFSET) < 256 and (vcount - Y_OFFSET) < 256, unsigned, with both inside the visible area.
- Stage 1 (on pix_en, from current counters):
  - oReadAddress = {vcount-Y_OFFSET, hcount-X_OFFSET}, low 8 bits each, when in_win; otherwise 0.
  - Register in_win, visible, and the raw sync levels.
  - hsync_raw is low for hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync_raw is low for vcount in 490..491.
- Stage 2 (next pix_en): RGB = iReadData when the stage-1 in_win flag is set, else 000. HSync and VSync take the stage-1 values.
- Latency: all five VGA outputs lag the counters by exactly one pixel (2 Clocks), so sync and colour stay aligned. iReadData is sampled 2 Clocks after oReadAddress changes; the RAM needs 1-Clock latency.
- Blanking: RGB is forced to 000 whenever the pixel is outside the visible area or outside the window.
- oFrameStart: high for exactly one Clock, on the pix_en where the counters move to hcount=0, vcount=V_VISIBLE. Exactly one pulse per frame, 840000 Clocks apart.
- Widths: counters are 10 bits; subtraction results are truncated to 8 bits and used only when in_win.
- No write path. Framebuffer contention with the CPU is resolved by the dual-port RAM, not by this block.

Optional Feature:
- Macro VGA_BORDER_EN.
- Defined: a 1-pixel white border (RGB 111) is drawn on the screen pixels immediately surrounding the window: columns X_OFFSET-1 and X_OFFSET+256 over lines Y_OFFSET-1..Y_OFFSET+256, and lines Y_OFFSET-1 and Y_OFFSET+256 over the same column span. The border takes the same 2-Clock output latency. The RAM address is still 0 on border pixels.
- Undefined: no border logic, and those pixels are black.

Test Plan:
- Reset held 3 Clocks, then released -> HSync=1, VSync=1, RGB=000, oReadAddress=0 during reset. First pix_en occurs on the 2nd Clock after release.
- Free run two lines -> HSync period 1600 Clocks, low width 192 Clocks, falling edge 1312 Clocks after the first output pixel of the line. RGB=000 whenever HSync is low.
- Free run two frames -> VSync period 840000 Clocks, low for 3200 Clocks; oFrameStart gives a single 1-Clock pulse per frame, 840000 Clocks apart.
- RAM model returns 3'b010 at address 0x0000 and 3'b100 at 0x00FF -> at hcount=192, vcount=112 the address is 0x0000 and green appears 2 Clocks later. At hcount=447 the address is 0x00FF and red follows. At hcount=448 RGB returns to 000.
- Assert Reset for 1 Clock at vcount=300, hcount=400 -> the next cycle shows counters 0 and outputs at reset values. The following frame's timing is identical to a frame started from power-up.
- With VGA_BORDER_EN and RAM all 000 -> RGB=111 at screen pixel (191,200) and (256+192,111); RGB=000 at (192,112) and (190,200).

Source files
------------

// File: rtl/vga_frame_reader_if.sv
// Framebuffer read port between the display reader (master) and the dual-port RAM (slave).
// Read data is returned one clock after the address is presented.
interface vga_frame_reader_if;
  logic [15:0] oReadAddress;
  logic [2:0]  iReadData;

  modport master (
    output oReadAddress,
    input  iReadData
  );

  modport slave (
    input  oReadAddress,
    output iReadData
  );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a 256x256 3-bit framebuffer placed in an on-screen window.
// Optional macro VGA_BORDER_EN draws a 1-pixel white frame around the window.
module vga_frame_reader #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned X_OFFSET  = 192,
  parameter int unsigned Y_OFFSET  = 112
) (
  input  logic               Clock,
  input  logic               Reset,
  vga_frame_reader_if.master fb,
  output logic               oVGA_Red,
  output logic               oVGA_Green,
  output logic               oVGA_Blue,
  output logic               oVGA_HSync,
  output logic               oVGA_VSync,
  output logic               oFrameStart
);

  localparam int unsigned CW      = 10;
  localparam int unsigned AW      = 16;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_VIS_M1 = CW'(V_VISIBLE - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] X_OFF    = CW'(X_OFFSET);
  localparam logic [CW-1:0] Y_OFF    = CW'(Y_OFFSET);
  localparam logic [CW-1:0] WIN_SIZE = CW'(256);

  // Pixel-rate toggle and raster counters
  logic          tog_q, tog_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;

  // Stage 1: address and per-pixel flags
  logic [AW-1:0] addr_q, addr_d;
  logic          in_win_q, in_win_d;
  logic          vis_q, vis_d;
  logic          hs_raw_q, hs_raw_d;
  logic          vs_raw_q, vs_raw_d;

  // Stage 2: output registers
  logic [2:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;

  logic          pix_en;
  logic          visible;
  logic          in_win;
  logic [CW-1:0] h_dx;
  logic [CW-1:0] v_dy;

`ifdef VGA_BORDER_EN
  localparam logic [CW-1:0] BX_L      = CW'(X_OFFSET - 1);
  localparam logic [CW-1:0] BX_R      = CW'(X_OFFSET + 256);
  localparam logic [CW-1:0] BY_T      = CW'(Y_OFFSET - 1);
  localparam logic [CW-1:0] BY_B      = CW'(Y_OFFSET + 256);
  localparam logic [CW-1:0] BORDER_SP = CW'(257);

  logic          border_q, border_d;
  logic          border;
  logic [CW-1:0] h_bd;
  logic [CW-1:0] v_bd;

  // Ring one pixel outside the window, spans measured from the top-left border corner
  always_comb begin
    h_bd   = hcount_q - BX_L;
    v_bd   = vcount_q - BY_T;
    border = visible &&
             ((((hcount_q == BX_L) || (hcount_q == BX_R)) && (v_bd <= BORDER_SP)) ||
              (((vcount_q == BY_T) || (vcount_q == BY_B)) && (h_bd <= BORDER_SP)));
  end
`endif

  always_comb begin
    h_dx    = hcount_q - X_OFF;
    v_dy    = vcount_q - Y_OFF;
    visible = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    in_win  = visible && (h_dx < WIN_SIZE) && (v_dy < WIN_SIZE);
  end

  always_comb begin
    pix_en        = tog_q;
    tog_d         = ~tog_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    addr_d        = addr_q;
    in_win_d      = in_win_q;
    vis_d         = vis_q;
    hs_raw_d      = hs_raw_q;
    vs_raw_d      = vs_raw_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
`ifdef VGA_BORDER_EN
    border_d      = border_q;
`endif

    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
      // Counters are stepping onto (0, V_VISIBLE): first line of vertical blanking
      frame_start_d = (hcount_q == H_LAST) && (vcount_q == V_VIS_M1);

      addr_d   = in_win ? {v_dy[7:0], h_dx[7:0]} : '0;
      in_win_d = in_win;
      vis_d    = visible;
      hs_raw_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vs_raw_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
`ifdef VGA_BORDER_EN
      border_d = border;
`endif

      hsync_d = hs_raw_q;
      vsync_d = vs_raw_q;
      rgb_d   = (in_win_q && vis_q) ? fb.iReadData : 3'b000;
`ifdef VGA_BORDER_EN
      if (border_q && vis_q) rgb_d = 3'b111;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tog_q         <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      addr_q        <= '0;
      in_win_q      <= 1'b0;
      vis_q         <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      rgb_q         <= 3'b000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef VGA_BORDER_EN
      border_q      <= 1'b0;
`endif
    end else begin
      tog_q         <= tog_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      addr_q        <= addr_d;
      in_win_q      <= in_win_d;
      vis_q         <= vis_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_BORDER_EN
      border_q      <= border_d;
`endif
    end
  end

  assign fb.oReadAddress = addr_q;
  assign oVGA_Red        = rgb_q[2];
  assign oVGA_Green      = rgb_q[1];
  assign oVGA_Blue       = rgb_q[0];
  assign oVGA_HSync      = hsync_q;
  assign oVGA_VSync      = vsync_q;
  assign oFrameStart     = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with a shortened vertical raster (10 lines/frame).
// Border expectations follow VGA_BORDER_EN.
module tb_vga_frame_reader;

  localparam int unsigned V_VIS = 6;
  localparam int unsigned V_FP  = 1;
  localparam int unsigned V_SW  = 2;
  localparam int unsigned V_BP  = 1;
  localparam int unsigned X_OFF = 192;
  localparam int unsigned Y_OFF = 2;

  // Clock counts for 800 px/line, 10 lines/frame, 2 clocks per pixel
  localparam int unsigned HS_FALL0 = 1314;   // 2*656 + 2-clock output lag
  localparam int unsigned HS_LOW   = 192;
  localparam int unsigned HS_PER   = 1600;
  localparam int unsigned VS_FALL0 = 11202;  // 2*(7*800) + 2
  localparam int unsigned VS_LOW   = 3200;
  localparam int unsigned VS_PER   = 16000;
  localparam int unsigned FS0      = 9598;   // 2*(6*800 - 1)
  localparam int unsigned FS_PER   = 16000;
  localparam int unsigned RUN_LEN  = 27300;

`ifdef VGA_BORDER_EN
  localparam logic [2:0] BRD = 3'b111;
`else
  localparam logic [2:0] BRD = 3'b000;
`endif

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic oVGA_Red, oVGA_Green, oVGA_Blue, oVGA_HSync, oVGA_VSync, oFrameStart;
  logic [2:0] rgb;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned blank_err = 0;
  int unsigned hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_q[$];
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;

  vga_frame_reader_if fb();

  vga_frame_reader #(
    .V_VISIBLE (V_VIS),
    .V_FRONT   (V_FP),
    .V_SYNC    (V_SW),
    .V_BACK    (V_BP),
    .X_OFFSET  (X_OFF),
    .Y_OFFSET  (Y_OFF)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .fb          (fb),
    .oVGA_Red    (oVGA_Red),
    .oVGA_Green  (oVGA_Green),
    .oVGA_Blue   (oVGA_Blue),
    .oVGA_HSync  (oVGA_HSync),
    .oVGA_VSync  (oVGA_VSync),
    .oFrameStart (oFrameStart)
  );

  assign rgb = {oVGA_Red, oVGA_Green, oVGA_Blue};

  always #10 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Framebuffer RAM model, 1-clock read latency
  always @(posedge Clock) begin
    case (fb.oReadAddress)
      16'h0000: fb.iReadData <= 3'b010;
      16'h00FF: fb.iReadData <= 3'b100;
      default:  fb.iReadData <= 3'b000;
    endcase
  end

  // Edge recorder: clock index of each sync/frame event, plus blanking violations
  always @(negedge Clock) begin
    if (prev_hs === 1'b1 && oVGA_HSync === 1'b0) hs_fall.push_back(cyc);
    if (prev_hs === 1'b0 && oVGA_HSync === 1'b1) hs_rise.push_back(cyc);
    if (prev_vs === 1'b1 && oVGA_VSync === 1'b0) vs_fall.push_back(cyc);
    if (prev_vs === 1'b0 && oVGA_VSync === 1'b1) vs_rise.push_back(cyc);
    if (oFrameStart === 1'b1) fs_q.push_back(cyc);
    if (oVGA_HSync === 1'b0 && rgb !== 3'b000) blank_err <= blank_err + 1;
    prev_hs <= oVGA_HSync;
    prev_vs <= oVGA_VSync;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_to(input int unsigned target);
    while (cyc < target) @(negedge Clock);
  endtask

  function automatic int unsigned qget(input int unsigned q[$], input int unsigned i);
    if (int'(i) < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "_hsync"}, 32'(oVGA_HSync), 32'd1);
    check({p, "_vsync"}, 32'(oVGA_VSync), 32'd1);
    check({p, "_rgb"},   32'(rgb), 32'd0);
    check({p, "_addr"},  32'(fb.oReadAddress), 32'd0);
    check({p, "_fs"},    32'(oFrameStart), 32'd0);
  endtask

  task automatic timing_checks(input string p, input int unsigned t0, input int unsigned hfb,
                               input int unsigned hrb, input int unsigned vfb,
                               input int unsigned vrb, input int unsigned fsb);
    check({p, "_hs_fall0"}, qget(hs_fall, hfb) - t0, HS_FALL0);
    check({p, "_hs_low"},   qget(hs_rise, hrb) - qget(hs_fall, hfb), HS_LOW);
    check({p, "_hs_per"},   qget(hs_fall, hfb + 1) - qget(hs_fall, hfb), HS_PER);
    check({p, "_vs_fall0"}, qget(vs_fall, vfb) - t0, VS_FALL0);
    check({p, "_vs_low"},   qget(vs_rise, vrb) - qget(vs_fall, vfb), VS_LOW);
    check({p, "_vs_per"},   qget(vs_fall, vfb + 1) - qget(vs_fall, vfb), VS_PER);
    check({p, "_fs0"},      qget(fs_q, fsb) - t0, FS0);
    check({p, "_fs_per"},   qget(fs_q, fsb + 1) - qget(fs_q, fsb), FS_PER);
    check({p, "_fs_cnt"},   32'(fs_q.size() - int'(fsb)), 32'd2);
  endtask

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic [15:0] addr;
    logic [2:0]  rgb;
  } pix_t;

  pix_t vec[7];
  int unsigned t0;
  int unsigned hfb, hrb, vfb, vrb, fsb;

  initial begin
    // Chronological screen pixels: (h, v, expected address, expected colour)
    vec[0] = '{448, 1, 16'h0000, BRD};
    vec[1] = '{192, 2, 16'h0000, 3'b010};
    vec[2] = '{447, 2, 16'h00FF, 3'b100};
    vec[3] = '{448, 2, 16'h0000, 3'b000};
    vec[4] = '{193, 3, 16'h0101, 3'b000};
    vec[5] = '{189, 4, 16'h0000, 3'b000};
    vec[6] = '{191, 4, 16'h0000, BRD};

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_reset_vals("rst");

    Reset = 1'b0;
    t0  = cyc + 2;
    hfb = hs_fall.size(); hrb = hs_rise.size();
    vfb = vs_fall.size(); vrb = vs_rise.size(); fsb = fs_q.size();

    // Stage-1 address at the pixel's tick, colour one pixel (2 clocks) later
    for (int i = 0; i < 7; i++) begin
      int unsigned n;
      n = vec[i].v * 800 + vec[i].h;
      step_to(t0 + 2 * n);
      check($sformatf("addr_%0d_%0d", vec[i].h, vec[i].v), 32'(fb.oReadAddress), 32'(vec[i].addr));
      step_to(t0 + 2 * n + 2);
      check($sformatf("rgb_%0d_%0d", vec[i].h, vec[i].v), 32'(rgb), 32'(vec[i].rgb));
    end

    step_to(t0 + RUN_LEN);
    timing_checks("run1", t0, hfb, hrb, vfb, vrb, fsb);

    // Third frame, line 4, column 400: address {2, 208}, then a one-clock reset
    step_to(t0 + 2 * (2 * 8000 + 4 * 800 + 400));
    check("pre_rst_addr", 32'(fb.oReadAddress), 32'h02D0);
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_vals("mid_rst");
    Reset = 1'b0;
    t0  = cyc + 2;
    hfb = hs_fall.size(); hrb = hs_rise.size();
    vfb = vs_fall.size(); vrb = vs_rise.size(); fsb = fs_q.size();
    step_to(t0 + RUN_LEN);
    timing_checks("run2", t0, hfb, hrb, vfb, vrb, fsb);

    check("blank_in_hsync", blank_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
